stopwatch_timebase: RTL
=======================

Name: stopwatch_timebase

Overview:
- Time-keeping datapath driven by the stopwatch control FSM's `time_en` count-enable output.
- Divides the 1000 Hz system clock down to 10 ms ticks and accumulates elapsed time as cascaded BCD digits, mm:ss.cc.
- Digit outputs feed the display scanner directly; `ovf` signals rollover.

Parameters:
- PRESCALE, 10, number of enabled clk cycles per centisecond tick (clk = 1000 Hz, so 10 gives 10 ms).
- PRE_W, 4, prescaler counter width; must satisfy 2^PRE_W >= PRESCALE.

Ports:
- clk  input  1  system clock, 1000 Hz
- rst  input  1  asynchronous, active-high reset
- time_en  input  1  count enable from the control FSM; level, not pulse
- clr  input  1  synchronous clear of the elapsed time
- lap  input  1  lap-hold button level, already debounced (used only with the optional feature)
- cs_lo  output  4  centiseconds units, BCD
- cs_hi  output  4  centiseconds tens, BCD
- sec_lo  output  4  seconds units, BCD 0-9
- sec_hi  output  4  seconds tens, BCD 0-5
- min_lo  output  4  minutes units, BCD 0-9
- min_hi  output  4  minutes tens, BCD 0-5
- ovf  output  1  one-cycle pulse on rollover 59:59.99 -> 00:00.00

Behaviour:
- Reset: `rst`=1 asynchronously clears the prescaler, all six digits, `ovf` and the lap-hold state to 0. All outputs are registered.
- Prescaler:
  - Counts 0..PRESCALE-1 only while `time_en`=1.
  - While `time_en`=0 it holds its value, so pause/resume preserves the sub-tick phase.
- Tick: asserted combinationally when prescaler==PRESCALE-1 and `time_en`=1. On that clock edge the prescaler returns to 0 and cs_lo increments.
- Count latency: with a continuous `time_en`, cs_lo first changes PRESCALE enabled cycles after the prescaler was 0.
- Digit cascade (each digit advances only when all lower digits are at terminal value on a tick):
  - cs_lo 9 -> 0 carries into cs_hi.
  - cs_hi 9 -> 0 carries into sec_lo.
  - sec_lo 9 -> 0 carries into sec_hi.
  - sec_hi 5 -> 0 carries into min_lo.
  - min_lo 9 -> 0 carries into min_hi.
  - min_hi 5 -> 0 is rollover.
- Rollover: on a tick at 59:59.99 all digits become 0 on the same edge, and `ovf`=1 for exactly that following cycle. `ovf`=0 otherwise.
- Clear:
  - `clr`=1 on an edge zeroes the prescaler and all digits and forces `ovf`=0.
  - `clr` has priority over a simultaneous tick.
  - `clr` is honoured regardless of `time_en`.
- Invalid BCD: a digit above its terminal value (only possible through an upset) is forced to 0 on its next update; no carry is produced.
- `time_en` toggling mid-tick: no partial increment occurs; counting resumes from the held prescaler value.
- Reset mid-count: all state returns to 0 immediately, and counting restarts from a zero phase after `rst` deasserts.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN
- Defined:
  - A rising edge of `lap` (registered-compare edge detect) toggles a hold flag.
  - While hold=1, the six digit outputs show a snapshot captured on the edge that set hold, and internal counting continues unaffected.
  - The edge that clears hold switches the outputs back to live values on the next cycle.
  - `clr` also clears hold.
  - `ovf` is never frozen.
- Undefined: the `lap` port still exists and is ignored; the outputs always show live digits. There is no snapshot register and no hold flag.

Decomposition:
- Shared package `stopwatch_pkg`:
  - BCD digit type (4 bits).
  - Terminal-value constants DIG_MAX_DEC=9 and DIG_MAX_SEX=5.
  - Default PRESCALE=10.
- One natural sub-module, `bcd_digit_cnt`, instantiated six times:
  - Parameter MAX.
  - Inputs: clk, rst, clr, inc.
  - Outputs: q[3:0], carry (carry = inc && q==MAX).

Test Plan:
- Reset/idle: assert `rst` mid-cycle with `time_en`=0 -> all digits 0 and `ovf`=0 asynchronously; 50 cycles with `time_en`=0 -> no change.
- Basic count: `time_en`=1 for 1000 cycles from reset -> 00:01.00 exactly; cs_lo increments every 10 cycles.
- Pause phase: `time_en`=1 for 7 cycles, 0 for 20 cycles, 1 for 3 cycles -> cs_lo=1 on the 3rd re-enabled cycle, not earlier.
- Cascade/rollover: count to 59:59.99 -> after 10 more enabled cycles all digits read 0, `ovf` high for exactly one cycle, and no intermediate illegal values (sec_hi never 6).
- Clear priority: assert `clr` on the cycle a tick is due, at 00:09.99 -> result 00:00.00, prescaler 0, no `ovf`.
- Lap (macro defined): at 00:02.50 pulse `lap` -> outputs stay at 00:02.50 while counting continues; pulse `lap` at live 00:04.00 -> outputs read 00:04.00 on the next cycle. Macro undefined: the same stimulus produces live outputs throughout.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase.
// The BCD digit type, the terminal values for the decimal and base-6 digits,
// the default prescale, and the per-digit terminal-value lookup.
package stopwatch_pkg;

    localparam int NUM_DIGITS   = 6;
    localparam int PRESCALE_DEF = 10;

    typedef logic [3:0] bcd_t;

    // Digit order, LSB first: cs_lo, cs_hi, sec_lo, sec_hi, min_lo, min_hi
    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    localparam bcd_t DIG_MAX_DEC = 4'd9;
    localparam bcd_t DIG_MAX_SEX = 4'd5;

    // sec_hi and min_hi count 0-5, every other digit counts 0-9
    function automatic bcd_t dig_max(input int idx);
        return (idx == 3 || idx == 5) ? DIG_MAX_SEX : DIG_MAX_DEC;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the elapsed-time cascade.
// It counts 0..MAX on each inc and wraps to 0. A value above MAX, which can
// only come from an upset, is forced to 0 on the next inc and produces no
// carry.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIG_MAX_DEC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    // Carry only from a legal terminal value, so a corrupted digit never ripples
    assign carry = inc && (q == MAX);

    // Digit register: clear has priority, and wrap/repair happen on inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q >= MAX) ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: a prescaler divides the 1 kHz clock into 10 ms ticks,
// and six cascaded BCD digits (mm:ss.cc) count those ticks.
// Optional macro STOPWATCH_LAP_HOLD_EN: a rising edge on lap toggles a hold
// flag. While hold is set, the digit outputs show a snapshot and counting
// continues. Without the macro, lap is ignored.
module stopwatch_timebase #(
    parameter int PRESCALE = stopwatch_pkg::PRESCALE_DEF,
    parameter int PRE_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       time_en,
    input  logic       clr,
    input  logic       lap,
    output logic [3:0] cs_lo,
    output logic [3:0] cs_hi,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       ovf
);
    import stopwatch_pkg::*;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    digits_t          live;
    digits_t          disp;

    assign tick = time_en && (pre == PRE_LAST);

    // Prescaler: advances only while enabled, so a pause keeps the sub-tick phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (time_en) begin
            pre <= (pre >= PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    // Digit cascade: each digit's inc is the carry of the digit below it.
    // Each stage has its own inc/cy nets, so no vector loops back on itself.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic inc;
        logic cy;
        if (i == 0) begin : g_first
            assign inc = tick;
        end else begin : g_next
            assign inc = g_dig[i-1].cy;
        end
        bcd_digit_cnt #(
            .MAX (dig_max(i))
        ) u_dig (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (inc),
            .q     (live[i]),
            .carry (cy)
        );
    end

    // Rollover pulse: the top digit's carry is exactly the 59:59.99 -> 00:00.00 tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else begin
            ovf <= g_dig[NUM_DIGITS-1].cy;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic    lap_q;
    logic    hold;
    digits_t snap;

    // Lap hold: edge-detect lap, toggle hold, and capture the live digits when hold is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            hold  <= 1'b0;
            snap  <= '0;
        end else begin
            lap_q <= lap;
            if (clr) begin
                hold <= 1'b0;
            end else if (lap && !lap_q) begin
                hold <= !hold;
                if (!hold) begin
                    snap <= live;
                end
            end
        end
    end

    assign disp = hold ? snap : live;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = live;
`endif

    assign cs_lo  = disp[0];
    assign cs_hi  = disp[1];
    assign sec_lo = disp[2];
    assign sec_hi = disp[3];
    assign min_lo = disp[4];
    assign min_hi = disp[5];

endmodule
